// File: rtl/uart_rx_if.sv
// Received-byte channel: byte plus error flags under valid/ready, and a sticky overrun flag.
// Latency: none, wiring only.
// Backpressure: the master holds rx_data and its flags until rx_valid & rx_ready.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART byte receiver: 2-FF sync, 3-sample mid-bit majority vote, start/8 data/[parity]/stop framing.
// Latency: rx_valid rises 1 clk after the stop-bit decision tick; parity compiled in by UART_RX_PARITY_EN.
// Backpressure: one holding register; a frame completing while it is still full is dropped and sets overrun.
module uart_rx_frame #(
    parameter int OVERSAMPLE = 32
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rx_tick,
    input  logic      rxd,
    uart_rx_if.master rx
);
    localparam int            TW     = $clog2(OVERSAMPLE);
    localparam int            H      = OVERSAMPLE / 2;
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_S0   = TW'(H - 1);
    localparam logic [TW-1:0] T_S1   = TW'(H);
    localparam logic [TW-1:0] T_DEC  = TW'(H + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rxs;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [1:0]    smp_q, smp_d;
    logic          vote;
    logic          dec;
    logic          wrap;
    logic          deliver;
    logic          hs;

    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          ovr_q;

    assign rxs  = sync_q[1];
    assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    assign dec  = rx_tick && (tcnt_q == T_DEC);
    assign wrap = rx_tick && (tcnt_q == T_LAST);
    assign hs   = valid_q & rx.rx_ready;

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    logic perr_o_q;
`endif

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        smp_d   = smp_q;
        deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        // Inside a frame the tick count free-runs; IDLE and BREAK pin it to 0.
        if (rx_tick && state_q != IDLE && state_q != BREAK) begin
            tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + 1'b1;
            if (tcnt_q == T_S0) smp_d[0] = rxs;
            if (tcnt_q == T_S1) smp_d[1] = rxs;
        end
        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (rx_tick && !rxs) begin
                    state_d = START;
                    tcnt_d  = TW'(1);
`ifdef UART_RX_PARITY_EN
                    perr_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (dec && vote) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                end else if (wrap) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (dec) shreg_d[idx_q] = vote;
                if (wrap) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (dec)  perr_d  = vote ^ (^shreg_q);
                if (wrap) state_d = STOP;
            end
`endif
            STOP: begin
                // Deliver at mid stop bit so the next start edge can follow immediately.
                if (dec) begin
                    deliver = 1'b1;
                    state_d = vote ? IDLE : BREAK;
                    tcnt_d  = '0;
                end
            end
            BREAK: begin
                tcnt_d = '0;
                if (rx_tick && rxs) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                tcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            tcnt_q  <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            smp_q   <= 2'b00;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rxd};
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            smp_q   <= smp_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_o_q <= 1'b0;
`endif
        end else begin
            if (deliver && (!valid_q || hs)) begin
                data_q  <= shreg_q;
                ferr_q  <= ~vote;
                valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                perr_o_q <= perr_q;
`endif
            end else if (hs) begin
                valid_q <= 1'b0;
            end
            if (deliver && valid_q && !hs) begin
                ovr_q <= 1'b1;
            end else if (hs) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = perr_o_q;
`else
    assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frame table plus glitch, break, overrun, coincident-handshake and reset sequences.
// Ticks are driven in phase with each bit (one tick every 2 clk), so decision cycles are known exactly.
module tb_uart_rx_frame;
    localparam int OS       = 32;
    localparam int BIT_CLKS = 2 * OS;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par;
        logic       exp_ferr;
        logic       perr_if_par;
    } vec_t;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic rx_tick = 1'b0;
    logic rxd     = 1'b1;
    logic rdy_base = 1'b1;
    logic prev_valid = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   valid_rises = 0;
    logic [9:0] got_q[$];

    uart_rx_if rxif();

    uart_rx_frame #(.OVERSAMPLE(OS)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_tick (rx_tick),
        .rxd     (rxd),
        .rx      (rxif)
    );

    always #5 clk = ~clk;

    // Record every accepted byte and every rx_valid rising edge.
    always @(negedge clk) begin
        if (!reset && rxif.rx_valid && rxif.rx_ready)
            got_q.push_back({rxif.rx_data, rxif.frame_err, rxif.parity_err});
        if (!reset && rxif.rx_valid && !prev_valid)
            valid_rises++;
        prev_valid = rxif.rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int low_clks, input int rdy_at);
        for (int c = 0; c < BIT_CLKS; c++) begin
            rxd           = (c < low_clks) ? 1'b0 : v;
            rx_tick       = (c % 2 == 0);
            rxif.rx_ready = (c == rdy_at) ? 1'b1 : rdy_base;
            step();
        end
        rx_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1, 0, -1);
    endtask

    task automatic low(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b0, 0, -1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int rdy_at);
        drive_bit(1'b0, 0, -1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 0, -1);
        if (PAR_EN) drive_bit(par, 0, -1);
        drive_bit(stop, 0, rdy_at);
    endtask

    task automatic expect_item(input string name, input logic [7:0] d, input logic f, input logic p);
        logic [9:0] it;
        it = (got_q.size() > 0) ? got_q.pop_front() : 10'h3FF;
        check({name, " data"}, 32'(it[9:2]), 32'(d));
        check({name, " frame_err"}, 32'(it[1]), 32'(f));
        check({name, " parity_err"}, 32'(it[0]), 32'(p));
    endtask

    task automatic set_ready(input logic r);
        rdy_base      = r;
        rxif.rx_ready = r;
    endtask

    initial begin
        vec_t vecs[8];
        int   rv;
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h6E, 1'b0, 1'b1, 1'b1, 1'b0};

        rxif.rx_ready = 1'b1;
        reset = 1'b1;
        repeat (4) step();
        reset = 1'b0;
        @(negedge clk);
        check("reset rx_valid", 32'(rxif.rx_valid), 32'd0);
        check("reset rx_data", 32'(rxif.rx_data), 32'd0);
        check("reset frame_err", 32'(rxif.frame_err), 32'd0);
        check("reset parity_err", 32'(rxif.parity_err), 32'd0);
        check("reset overrun", 32'(rxif.overrun), 32'd0);
        step();
        idle(1);

        for (int i = 0; i < 8; i++) begin
            set_ready(1'b1);
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par, -1);
            idle(2);
            check($sformatf("vec%0d count", i), 32'(got_q.size()), 32'd1);
            expect_item($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_ferr,
                        PAR_EN & vecs[i].perr_if_par);
        end

        // Short low glitch on the idle line: false start, nothing reported.
        rv = valid_rises;
        drive_bit(1'b1, 2, -1);
        idle(2);
        check("glitch valid_rises", 32'(valid_rises), 32'(rv));
        check("glitch rx_valid", 32'(rxif.rx_valid), 32'd0);
        check("glitch count", 32'(got_q.size()), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        idle(2);
        check("post-glitch count", 32'(got_q.size()), 32'd1);
        expect_item("post-glitch", 8'h5A, 1'b0, 1'b0);

        // Framing error followed by a held line break.
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        low(3);
        check("break count", 32'(got_q.size()), 32'd1);
        expect_item("break 3C", 8'h3C, 1'b1, 1'b0);
        idle(1);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        idle(2);
        check("after-break count", 32'(got_q.size()), 32'd1);
        expect_item("after-break 81", 8'h81, 1'b0, 1'b0);

        // Overrun: second back-to-back frame dropped while the first is held.
        set_ready(1'b0);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        idle(1);
        @(negedge clk);
        check("ovr rx_valid", 32'(rxif.rx_valid), 32'd1);
        check("ovr rx_data", 32'(rxif.rx_data), 32'h11);
        check("ovr overrun", 32'(rxif.overrun), 32'd1);
        step();
        set_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        check("ovr hs rx_valid", 32'(rxif.rx_valid), 32'd0);
        check("ovr hs overrun", 32'(rxif.overrun), 32'd0);
        step();
        check("ovr count", 32'(got_q.size()), 32'd1);
        expect_item("ovr 11", 8'h11, 1'b0, 1'b0);

        // Handshake on the exact stop-decision cycle (37th clk of the stop bit).
        set_ready(1'b0);
        send_frame(8'h5C, 1'b1, 1'b0, -1);
        idle(1);
        send_frame(8'hC3, 1'b1, 1'b0, 36);
        @(negedge clk);
        check("coinc rx_valid", 32'(rxif.rx_valid), 32'd1);
        check("coinc rx_data", 32'(rxif.rx_data), 32'hC3);
        check("coinc overrun", 32'(rxif.overrun), 32'd0);
        step();
        check("coinc first count", 32'(got_q.size()), 32'd1);
        expect_item("coinc 5C", 8'h5C, 1'b0, 1'b0);
        set_ready(1'b1);
        idle(1);
        check("coinc second count", 32'(got_q.size()), 32'd1);
        expect_item("coinc C3", 8'hC3, 1'b0, 1'b0);

        // Reset mid-DATA with a byte held and overrun set.
        set_ready(1'b0);
        send_frame(8'h99, 1'b0, 1'b0, -1);
        idle(1);
        send_frame(8'h66, 1'b1, 1'b0, -1);
        idle(1);
        @(negedge clk);
        check("pre-reset overrun", 32'(rxif.overrun), 32'd1);
        check("pre-reset frame_err", 32'(rxif.frame_err), 32'd1);
        step();
        drive_bit(1'b0, 0, -1);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 0, -1);
        reset   = 1'b1;
        rx_tick = 1'b0;
        rxd     = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        @(negedge clk);
        check("midreset rx_valid", 32'(rxif.rx_valid), 32'd0);
        check("midreset rx_data", 32'(rxif.rx_data), 32'd0);
        check("midreset frame_err", 32'(rxif.frame_err), 32'd0);
        check("midreset parity_err", 32'(rxif.parity_err), 32'd0);
        check("midreset overrun", 32'(rxif.overrun), 32'd0);
        step();
        set_ready(1'b1);
        idle(1);
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        idle(2);
        check("post-reset count", 32'(got_q.size()), 32'd1);
        expect_item("post-reset 5A", 8'h5A, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
